// File: rtl/noc_input_buffer_if.sv
// Handshake bundle between a NoC link/switch stage and the per-port input buffer.
// The master drives the push/pop side; the slave is the buffer itself.
interface noc_input_buffer_if #(
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 5
);
    logic                         ib_valid_i;
    logic [DATA_WIDTH-1:0]        ib_data_i;
    logic                         ib_pop_i;
    logic                         ib_valid_o;
    logic [DATA_WIDTH-1:0]        ib_data_o;
    logic [$clog2(DEPTH+1)-1:0]   ib_count_o;
    logic                         ib_credit_o;
    logic                         ib_overflow_o;

    modport master (
        output ib_valid_i, ib_data_i, ib_pop_i,
        input  ib_valid_o, ib_data_o, ib_count_o, ib_credit_o, ib_overflow_o
    );

    modport slave (
        input  ib_valid_i, ib_data_i, ib_pop_i,
        output ib_valid_o, ib_data_o, ib_count_o, ib_credit_o, ib_overflow_o
    );
endinterface

// File: rtl/noc_input_buffer.sv
// Per-port NoC input FIFO with first-word fall-through head and credit-return pulse.
// Define IB_OVERFLOW_CHECK_EN to get a sticky flag on pushes dropped while full.
module noc_input_buffer #(
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 5
) (
    input  logic              clk,
    input  logic              reset,
    noc_input_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  credit;
    logic                  pop_ok;
    logic                  push_ok;

    // A pop frees a slot in the same cycle, so a push at full is still taken.
    assign pop_ok  = bus.ib_pop_i & (count != '0);
    assign push_ok = bus.ib_valid_i & ((count < FULL_COUNT) | pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            credit <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            credit <= pop_ok;
            if (push_ok) begin
                mem[wr_ptr] <= bus.ib_data_i;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.ib_valid_o  = (count != '0);
    assign bus.ib_data_o   = mem[rd_ptr];
    assign bus.ib_count_o  = count;
    assign bus.ib_credit_o = credit;

`ifdef IB_OVERFLOW_CHECK_EN
    logic overflow;

    // Sticky until reset so software can spot a sender that ignored credits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (bus.ib_valid_i && !push_ok) begin
            overflow <= 1'b1;
        end
    end

    assign bus.ib_overflow_o = overflow;
`else
    assign bus.ib_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer: directed vector table, corner-case
// sequences and randomized traffic checked against a queue-based reference model.
module tb_noc_input_buffer;
    localparam int DW    = 34;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          pop;
        logic          exp_valid;
        logic [CW-1:0] exp_count;
        logic [DW-1:0] exp_data;
        logic          exp_credit;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] model_q[$];
    logic          model_credit = 1'b0;
    logic          model_overflow = 1'b0;
    vec_t          vecs[11];

    noc_input_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    noc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic p,
                                input logic ev, input int ec, input logic [DW-1:0] ed,
                                input logic ecr);
        vec_t r;
        r.valid = v; r.data = d; r.pop = p;
        r.exp_valid = ev; r.exp_count = CW'(ec); r.exp_data = ed; r.exp_credit = ecr;
        return r;
    endfunction

    // One clock: drive inputs, advance the model with pre-edge state, compare after the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic p);
        logic pop_ok;
        logic push_ok;
        bus.ib_valid_i = v;
        bus.ib_data_i  = d;
        bus.ib_pop_i   = p;
        pop_ok  = p && (model_q.size() != 0);
        push_ok = v && ((model_q.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        model_credit = pop_ok;
`ifdef IB_OVERFLOW_CHECK_EN
        if (v && !push_ok) model_overflow = 1'b1;
`endif
        @(posedge clk);
        #1;
        check("model_count", 64'(bus.ib_count_o), 64'(model_q.size()));
        check("model_valid", 64'(bus.ib_valid_o), 64'(model_q.size() != 0));
        check("model_credit", 64'(bus.ib_credit_o), 64'(model_credit));
        check("model_overflow", 64'(bus.ib_overflow_o), 64'(model_overflow));
        if (model_q.size() != 0) check("model_head", 64'(bus.ib_data_o), 64'(model_q[0]));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        // Fill 0x1..0x5 then drain; stale head after draining is mem[0] = 0x1.
        vecs[0]  = mk(1, 34'h1, 0, 1, 1, 34'h1, 0);
        vecs[1]  = mk(1, 34'h2, 0, 1, 2, 34'h1, 0);
        vecs[2]  = mk(1, 34'h3, 0, 1, 3, 34'h1, 0);
        vecs[3]  = mk(1, 34'h4, 0, 1, 4, 34'h1, 0);
        vecs[4]  = mk(1, 34'h5, 0, 1, 5, 34'h1, 0);
        vecs[5]  = mk(0, 34'h0, 1, 1, 4, 34'h2, 1);
        vecs[6]  = mk(0, 34'h0, 1, 1, 3, 34'h3, 1);
        vecs[7]  = mk(0, 34'h0, 1, 1, 2, 34'h4, 1);
        vecs[8]  = mk(0, 34'h0, 1, 1, 1, 34'h5, 1);
        vecs[9]  = mk(0, 34'h0, 1, 0, 0, 34'h1, 1);
        vecs[10] = mk(0, 34'h0, 0, 0, 0, 34'h1, 0);

        bus.ib_valid_i = 1'b0;
        bus.ib_data_i  = '0;
        bus.ib_pop_i   = 1'b0;

        #2;
        check("reset_count", 64'(bus.ib_count_o), 64'd0);
        check("reset_valid", 64'(bus.ib_valid_o), 64'd0);
        check("reset_data", 64'(bus.ib_data_o), 64'd0);
        check("reset_credit", 64'(bus.ib_credit_o), 64'd0);
        check("reset_overflow", 64'(bus.ib_overflow_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].pop);
            check($sformatf("vec%0d_valid", i), 64'(bus.ib_valid_o), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 64'(bus.ib_count_o), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_data", i), 64'(bus.ib_data_o), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_credit", i), 64'(bus.ib_credit_o), 64'(vecs[i].exp_credit));
        end

        // Empty pops must be ignored entirely.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            check("empty_pop_credit", 64'(bus.ib_credit_o), 64'd0);
            check("empty_pop_count", 64'(bus.ib_count_o), 64'd0);
        end

        // Wrap: hold occupancy at 2 while pairs stream through the ring.
        step(1'b1, 34'h0E, 1'b0);
        step(1'b1, 34'h0F, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, DW'(34'h10 + i), 1'b1);
            check("wrap_count", 64'(bus.ib_count_o), 64'd2);
        end
        step(1'b0, '0, 1'b1);
        check("wrap_head_1a", 64'(bus.ib_data_o), 64'h1B);
        step(1'b0, '0, 1'b1);

        // Full with a simultaneous push/pop: 0xAA accepted and read out fifth.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(34'h20 + i), 1'b0);
        check("full_count", 64'(bus.ib_count_o), 64'd5);
        step(1'b1, 34'hAA, 1'b1);
        check("full_pushpop_count", 64'(bus.ib_count_o), 64'd5);
        check("full_pushpop_overflow", 64'(bus.ib_overflow_o), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("aa_fifth", 64'(bus.ib_data_o), 64'hAA);
        step(1'b0, '0, 1'b1);

        // Push at full with no pop is dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(34'h30 + i), 1'b0);
        step(1'b1, 34'hBB, 1'b0);
        check("drop_count", 64'(bus.ib_count_o), 64'd5);
        check("drop_head", 64'(bus.ib_data_o), 64'h30);
`ifdef IB_OVERFLOW_CHECK_EN
        check("overflow_set", 64'(bus.ib_overflow_o), 64'd1);
`else
        check("overflow_tied", 64'(bus.ib_overflow_o), 64'd0);
`endif
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), DW'({$urandom, $urandom}),
                 1'($urandom_range(0, 99) < 50));
        end

        // Async reset mid-cycle with three flits stored.
        while (model_q.size() != 0) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, DW'(34'h40 + i), 1'b0);
        bus.ib_valid_i = 1'b0;
        bus.ib_pop_i   = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("midreset_count", 64'(bus.ib_count_o), 64'd0);
        check("midreset_valid", 64'(bus.ib_valid_o), 64'd0);
        check("midreset_data", 64'(bus.ib_data_o), 64'd0);
        check("midreset_credit", 64'(bus.ib_credit_o), 64'd0);
        check("midreset_overflow", 64'(bus.ib_overflow_o), 64'd0);
        model_q.delete();
        model_credit   = 1'b0;
        model_overflow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("postreset_credit", 64'(bus.ib_credit_o), 64'd0);
        end
        check("postreset_count", 64'(bus.ib_count_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
